sdram_phy: RTL

Parametrised SDRAM physical layer for ECP5, sitting between the SDRAM controller and the board pins. It registers all command, address, mask and write data outputs in I/O-adjacent flops. It drives a phase-inverted SDRAM clock from an ODDR and captures read data in input registers. A read-return pipeline tracks in-flight READ bursts and hands the controller a `rd_valid`-qualified data stream, so the controller no longer counts CAS latency itself.

---
 rtl/sdram_phy.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sdram_phy.sv
// sdram_phy: ECP5 SDRAM PHY with registered command/data pins, an inverted pin clock and a read-return pipeline.
// Define SDRAM_PHY_DQ_IREG_EN to add a second DQ capture register (read latency +1 cycle).
module sdram_phy #(
  parameter int AWIDTH      = 12,
  parameter int BWIDTH      = 2,
  parameter int DWIDTH      = 16,
  parameter int CSWIDTH     = 1,
  parameter int CAS_LATENCY = 2,
  parameter int BURST_LEN   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  pin_clk,
  output logic                  pin_cke,
  output logic [CSWIDTH-1:0]    pin_cs_n,
  output logic                  pin_ras_n,
  output logic                  pin_cas_n,
  output logic                  pin_we_n,
  output logic [BWIDTH-1:0]     pin_ba,
  output logic [AWIDTH-1:0]     pin_addr,
  output logic [DWIDTH/8-1:0]   pin_dqm,
  inout  wire  [DWIDTH-1:0]     pin_data,
  input  logic                  cke,
  input  logic [CSWIDTH-1:0]    cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BWIDTH-1:0]     ba,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [DWIDTH/8-1:0]   dqm,
  input  logic [DWIDTH-1:0]     wr_data,
  input  logic                  wr_en,
  output logic [DWIDTH-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  bus_conflict
);

`ifdef SDRAM_PHY_DQ_IREG_EN
  localparam int IREG = 1;
`else
  localparam int IREG = 0;
`endif
  localparam int L   = CAS_LATENCY + 2 + IREG;
  localparam int SRW = L + BURST_LEN - 1;
  localparam int MW  = DWIDTH / 8;

  logic               cke_d, cke_q, ras_n_d, ras_n_q, cas_n_d, cas_n_q, we_n_d, we_n_q;
  logic [CSWIDTH-1:0] cs_n_d, cs_n_q;
  logic [BWIDTH-1:0]  ba_d, ba_q;
  logic [AWIDTH-1:0]  addr_d, addr_q;
  logic [MW-1:0]      dqm_d, dqm_q;
  logic [DWIDTH-1:0]  dout_d, dout_q, oe_d, oe_q, cap_d, cap_q;
  logic [SRW-1:0]     sr_d, sr_q;
  logic               is_read, rd_valid_d, rd_valid_q, conflict_d, conflict_q;

  // Behavioural ODDR (D0=0, D1=1): pin clock rises mid-cycle, 180 degrees from clk.
  assign pin_clk = ~clk;

  for (genvar i = 0; i < DWIDTH; i++) begin : g_dq
    assign pin_data[i] = oe_q[i] ? dout_q[i] : 1'bz;
  end

  always_comb begin
    cke_d   = cke;
    cs_n_d  = cs_n;
    ras_n_d = ras_n;
    cas_n_d = cas_n;
    we_n_d  = we_n;
    ba_d    = ba;
    addr_d  = addr;
    dqm_d   = dqm;
    dout_d  = wr_data;
    oe_d    = {DWIDTH{wr_en}};
    cap_d   = pin_data;
    is_read = (~&cs_n) & ras_n & ~cas_n & we_n;
    sr_d    = {sr_q[SRW-2:0], is_read};
    // Taps one stage early: high while a beat is on the pins, and becomes rd_valid next cycle.
    rd_valid_d = |sr_q[SRW-2:L-2];
    conflict_d = conflict_q | (oe_q[0] & rd_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cke_q      <= 1'b0;
      cs_n_q     <= '1;
      ras_n_q    <= 1'b1;
      cas_n_q    <= 1'b1;
      we_n_q     <= 1'b1;
      ba_q       <= '0;
      addr_q     <= '0;
      dqm_q      <= '1;
      dout_q     <= '0;
      oe_q       <= '0;
      cap_q      <= '0;
      sr_q       <= '0;
      rd_valid_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      cke_q      <= cke_d;
      cs_n_q     <= cs_n_d;
      ras_n_q    <= ras_n_d;
      cas_n_q    <= cas_n_d;
      we_n_q     <= we_n_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      dqm_q      <= dqm_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      cap_q      <= cap_d;
      sr_q       <= sr_d;
      rd_valid_q <= rd_valid_d;
      conflict_q <= conflict_d;
    end
  end

`ifdef SDRAM_PHY_DQ_IREG_EN
  logic [DWIDTH-1:0] cap2_d, cap2_q;

  always_comb cap2_d = cap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cap2_q <= '0;
    else        cap2_q <= cap2_d;
  end

  assign rd_data = cap2_q;
`else
  assign rd_data = cap_q;
`endif

  assign pin_cke      = cke_q;
  assign pin_cs_n     = cs_n_q;
  assign pin_ras_n    = ras_n_q;
  assign pin_cas_n    = cas_n_q;
  assign pin_we_n     = we_n_q;
  assign pin_ba       = ba_q;
  assign pin_addr     = addr_q;
  assign pin_dqm      = dqm_q;
  assign rd_valid     = rd_valid_q;
  assign bus_conflict = conflict_q;

endmodule
